io_responder: RTL and testbench



---
 rtl/io_responder.sv | 157 +++++++++++++++
 tb/tb_io_responder.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/io_responder.sv
// io_responder: memory-mapped IO page target with an LED register and an
// 8N1 UART transmitter. Stores take effect at the next edge with no wait
// states. Reads are registered and return data one cycle after the strobe.
module io_responder #(
  parameter int IO_BIT       = 22,
  parameter int CLKS_PER_BIT = 434
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wmask,
  input  logic        mem_rstrb,
  output logic [31:0] mem_rdata,
  output logic [4:0]  LEDS,
  output logic        TXD,
  output logic        uart_busy
);

  localparam int                CW     = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0]     CPB_M1 = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } uart_state_t;

  // Bus decode. Only the three one-hot word bits are meaningful; the rest of
  // the word index is ignored, so aliases of the registers exist in the page.
  logic        w_sel;
  logic [2:0]  w_word;
  logic        w_wr;
  logic        w_rd;
  logic        w_led_wr;
  logic        w_uart_start;
  logic [31:0] w_rd_data;
  logic        w_unused;

  assign w_sel    = mem_addr[IO_BIT];
  assign w_word   = mem_addr[4:2];
  assign w_wr     = w_sel & (|mem_wmask);
  assign w_rd     = w_sel & mem_rstrb;
  assign w_led_wr = w_wr & w_word[0] & mem_wmask[0];
  assign w_unused = ^{mem_addr[31:IO_BIT+1], mem_addr[IO_BIT-1:5], mem_addr[1:0],
                      mem_wdata[31:8]};

  // Read mux: OR of every selected source, so multi-select reads merge.
  assign w_rd_data = (w_word[0] ? {27'b0, LEDS} : 32'b0)
                   | (w_word[2] ? {22'b0, uart_busy, 9'b0} : 32'b0);

  // UART state.
  uart_state_t r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [2:0]    r_idx, w_idx_nxt;
  logic [7:0]    r_shift, w_shift_nxt;
  logic          r_txd, w_txd_nxt;
  logic          w_cnt_zero;

  // A UART_DAT store is accepted only while idle; a store during a frame is dropped.
  assign w_uart_start = w_wr & w_word[1] & mem_wmask[0] & (r_state == S_IDLE);
  assign w_cnt_zero   = (r_cnt == '0);
  assign uart_busy    = (r_state != S_IDLE);
  assign TXD          = r_txd;

  // LED register and registered read data.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values; this is what makes a same-cycle read return
    // the LED value from before the write.
    if (reset) begin
      LEDS      <= 5'b0;
      mem_rdata <= 32'b0;
    end else begin
      if (w_led_wr) LEDS <= mem_wdata[4:0];
      if (w_rd)     mem_rdata <= w_rd_data;
    end
  end

  // UART state register; TXD is registered so the line never glitches.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_idx   <= 3'd0;
      r_shift <= 8'd0;
      r_txd   <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
      r_shift <= w_shift_nxt;
      r_txd   <= w_txd_nxt;
    end
  end

  // UART next-state: each bit state lasts CLKS_PER_BIT cycles, data LSB first.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_idx_nxt   = r_idx;
    w_shift_nxt = r_shift;
    w_txd_nxt   = r_txd;
    unique case (r_state)
      S_IDLE: begin
        w_txd_nxt = 1'b1;
        if (w_uart_start) begin
          w_state_nxt = S_START;
          w_cnt_nxt   = CPB_M1;
          w_idx_nxt   = 3'd0;
          w_shift_nxt = mem_wdata[7:0];
          w_txd_nxt   = 1'b0;
        end
      end
      S_START: begin
        if (w_cnt_zero) begin
          w_state_nxt = S_DATA;
          w_cnt_nxt   = CPB_M1;
          w_txd_nxt   = r_shift[0];
          w_shift_nxt = {1'b0, r_shift[7:1]};
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      S_DATA: begin
        if (w_cnt_zero) begin
          w_cnt_nxt = CPB_M1;
          if (r_idx == 3'd7) begin
            w_state_nxt = S_STOP;
            w_txd_nxt   = 1'b1;
          end else begin
            w_idx_nxt   = r_idx + 3'd1;
            w_txd_nxt   = r_shift[0];
            w_shift_nxt = {1'b0, r_shift[7:1]};
          end
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      S_STOP: begin
        if (w_cnt_zero) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_txd_nxt   = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_io_responder.sv
// Directed testbench for io_responder with CLKS_PER_BIT = 4. Inputs change
// and outputs are sampled on the falling edge, away from the active edge.
module tb_io_responder;

  localparam int CPB = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_rstrb;
  logic [31:0] mem_rdata;
  logic [4:0]  LEDS;
  logic        TXD;
  logic        uart_busy;

  int total = 0;
  int bad   = 0;

  io_responder #(.IO_BIT(22), .CLKS_PER_BIT(CPB)) dut (
    .clk       (clk),
    .reset     (reset),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wmask (mem_wmask),
    .mem_rstrb (mem_rstrb),
    .mem_rdata (mem_rdata),
    .LEDS      (LEDS),
    .TXD       (TXD),
    .uart_busy (uart_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic bus_idle();
    mem_addr  = 32'h0;
    mem_wdata = 32'h0;
    mem_wmask = 4'h0;
    mem_rstrb = 1'b0;
  endtask

  task automatic store(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] mask);
    mem_addr  = addr;
    mem_wdata = data;
    mem_wmask = mask;
    @(negedge clk);
    bus_idle();
  endtask

  task automatic load(input logic [31:0] addr);
    mem_addr  = addr;
    mem_rstrb = 1'b1;
    @(negedge clk);
    bus_idle();
  endtask

  // Checks a whole frame starting in its first cycle. Optionally drives a
  // busy-time store (inject_at) or a UART_CNTL read (rd_at) at a frame cycle.
  task automatic check_frame(input logic [7:0] data, input int inject_at, input int rd_at);
    logic exp_bit;
    for (int k = 0; k < 10 * CPB; k++) begin
      bus_idle();
      if (rd_at >= 0 && k == rd_at + 1) check("cntl_mid_frame", mem_rdata, 32'h200);
      if (k / CPB == 0)      exp_bit = 1'b0;
      else if (k / CPB == 9) exp_bit = 1'b1;
      else                   exp_bit = data[k / CPB - 1];
      check($sformatf("txd_%0d", k), {31'b0, TXD}, {31'b0, exp_bit});
      check($sformatf("busy_%0d", k), {31'b0, uart_busy}, 32'h1);
      if (k == inject_at) begin
        mem_addr  = 32'h0040_0008;
        mem_wdata = 32'h0000_003C;
        mem_wmask = 4'hF;
      end
      if (k == rd_at) begin
        mem_addr  = 32'h0040_0010;
        mem_rstrb = 1'b1;
      end
      @(negedge clk);
    end
    bus_idle();
    check("busy_end", {31'b0, uart_busy}, 32'h0);
    check("txd_end", {31'b0, TXD}, 32'h1);
  endtask

  initial begin
    bus_idle();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_leds", {27'b0, LEDS}, 32'h0);
    check("rst_txd", {31'b0, TXD}, 32'h1);
    check("rst_busy", {31'b0, uart_busy}, 32'h0);
    check("rst_rdata", mem_rdata, 32'h0);

    // LED register write and read-back.
    store(32'h0040_0004, 32'h0000_001F, 4'b1111);
    check("led_write", {27'b0, LEDS}, 32'h1F);
    load(32'h0040_0004);
    check("led_read", mem_rdata, 32'h1F);
    store(32'h0040_0004, 32'h0000_000A, 4'b0010);
    check("led_mask_b0_clear", {27'b0, LEDS}, 32'h1F);

    // Read and write together: read returns the old value.
    mem_addr  = 32'h0040_0004;
    mem_wdata = 32'h0000_0003;
    mem_wmask = 4'hF;
    mem_rstrb = 1'b1;
    @(negedge clk);
    bus_idle();
    check("rw_same_rdata", mem_rdata, 32'h1F);
    check("rw_same_leds", {27'b0, LEDS}, 32'h03);

    // Outside the IO page: no write, no read update.
    store(32'h0000_0004, 32'h0000_000A, 4'hF);
    check("nosel_leds", {27'b0, LEDS}, 32'h03);
    load(32'h0000_0004);
    check("nosel_rdata", mem_rdata, 32'h1F);

    // LEDS and UART_CNTL selected together while idle.
    load(32'h0040_0014);
    check("multi_sel_read", mem_rdata, 32'h03);

    // Frame 0xA5 with a mid-frame status read.
    store(32'h0040_0008, 32'h0000_00A5, 4'hF);
    check_frame(8'hA5, -1, 20);
    check("rdata_hold", mem_rdata, 32'h200);
    load(32'h0040_0010);
    check("cntl_idle", mem_rdata, 32'h0);

    // Store while busy is dropped; no second frame follows.
    store(32'h0040_0008, 32'h0000_00A5, 4'hF);
    check_frame(8'hA5, 4, -1);
    for (int k = 0; k < 12 * CPB; k++) begin
      check("no_2nd_txd", {31'b0, TXD}, 32'h1);
      check("no_2nd_busy", {31'b0, uart_busy}, 32'h0);
      @(negedge clk);
    end

    // Back-to-back frames: store in the first non-busy cycle.
    store(32'h0040_0008, 32'h0000_00A5, 4'hF);
    check_frame(8'hA5, -1, -1);
    store(32'h0040_0008, 32'h0000_003C, 4'hF);
    check_frame(8'h3C, -1, -1);

    // Reset during cycle 12 of a frame.
    store(32'h0040_0004, 32'h0000_0015, 4'hF);
    store(32'h0040_0008, 32'h0000_0055, 4'hF);
    repeat (11) @(negedge clk);
    check("pre_rst_busy", {31'b0, uart_busy}, 32'h1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midrst_txd", {31'b0, TXD}, 32'h1);
    check("midrst_busy", {31'b0, uart_busy}, 32'h0);
    check("midrst_leds", {27'b0, LEDS}, 32'h0);
    check("midrst_rdata", mem_rdata, 32'h0);
    @(negedge clk);
    check("post_rst_txd", {31'b0, TXD}, 32'h1);

    // A new frame after reset transmits correctly.
    store(32'h0040_0008, 32'h0000_0081, 4'hF);
    check_frame(8'h81, -1, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
